apb_mem_completer: RTL and testbench

Synthesizable APB4 completer backed by a word-addressed memory. It consumes the requester signals (paddr, pprot, psel, penable, pwrite, pwdata, pstrb) and produces the completer signals (pready, prdata, pslverr). It is the DUT-side counterpart used to close the loop on the APB agent in self-test benches. Wait states are programmable per transfer, and out-of-range or illegal accesses return an error response.

---
 rtl/apb_agent_pkg.sv | 23 ++
 rtl/apb_cmp_mem.sv | 36 +++
 rtl/apb_mem_completer.sv | 127 ++++++++++++
 tb/tb_apb_mem_completer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_agent_pkg.sv
// Shared APB agent types plus the completer-side FSM state and error-count limit.
package apb_agent_pkg;

  typedef enum logic {
    APB_READ  = 1'b0,
    APB_WRITE = 1'b1
  } apb_write_e;

  // pprot[0] = privileged, pprot[1] = non-secure, pprot[2] = instruction
  typedef struct packed {
    logic instr;
    logic nonsecure;
    logic priv;
  } apb_pprot_t;

  typedef enum logic {
    APB_CMP_IDLE,
    APB_CMP_ACCESS
  } apb_cmp_state_e;

  localparam logic [7:0] APB_CMP_ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/apb_cmp_mem.sv
// Word array with per-byte synchronous write, asynchronous read, async clear to zero.
// Each byte lane is its own array so that lanes never share a driver.
module apb_cmp_mem
  import apb_agent_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] lane [MEM_DEPTH];

    // Byte lane b: cleared on reset, written only when its strobe is set
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < MEM_DEPTH; i++) lane[i] <= '0;
      end else if (we && wstrb[b]) begin
        lane[waddr] <= wdata[b*8 +: 8];
      end
    end

    assign rdata[b*8 +: 8] = lane[raddr];
  end

endmodule

// File: rtl/apb_mem_completer.sv
// APB4 completer over a word memory: programmable wait states, range and
// privilege checks, protocol-violation handling and a saturating error count.
module apb_mem_completer
  import apb_agent_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int MEM_DEPTH       = 256,
  parameter int PRIV_WRITE_ONLY = 0
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [3:0]              cfg_wait,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic [7:0]              err_count
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int AW   = $clog2(MEM_DEPTH);

  apb_cmp_state_e  state, state_nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  apb_write_e      wr_q;
  logic            err_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_q, mem_rdata;
  logic [NB-1:0]   strb_q;

  apb_pprot_t      prot;
  logic            unused_prot;
  logic [31:0]     idx_full;
  logic            in_range, setup, done, no_setup, mem_we;

  assign prot        = apb_pprot_t'(pprot);
  assign unused_prot = prot.instr ^ prot.nonsecure;

  // Byte offset bits are dropped; out-of-range is judged on the full index
  assign idx_full = 32'(paddr) >> OFFS;
  assign in_range = idx_full < 32'(MEM_DEPTH);

  assign setup    = (state == APB_CMP_IDLE) && psel && !penable;
  assign done     = (state == APB_CMP_ACCESS) && psel && penable && (cnt == 4'd0);
  assign no_setup = (state == APB_CMP_IDLE) && psel && penable;
  assign mem_we   = done && (wr_q == APB_WRITE) && !err_q;

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= APB_CMP_IDLE;
    else           state <= state_nxt;
  end

  // Next state: setup opens a transfer; completion or a dropped psel closes it
  always_comb begin
    state_nxt = state;
    case (state)
      APB_CMP_IDLE:   if (psel && !penable) state_nxt = APB_CMP_ACCESS;
      APB_CMP_ACCESS: if (!psel || (penable && cnt == 4'd0)) state_nxt = APB_CMP_IDLE;
      default:        state_nxt = APB_CMP_IDLE;
    endcase
  end

  // Response outputs; forced low while reset is held so they drop immediately
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (preset_n) begin
      pready  = done || no_setup;
      pslverr = (done && err_q) || no_setup;
      if (done && (wr_q == APB_READ) && !err_q) prdata = rd_q;
    end
  end

  // Setup-cycle capture of the request and wait-state countdown
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= APB_READ;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rd_q    <= '0;
    end else if (setup) begin
      cnt     <= cfg_wait;
      idx_q   <= idx_full[AW-1:0];
      wr_q    <= apb_write_e'(pwrite);
      err_q   <= !in_range || ((PRIV_WRITE_ONLY != 0) && pwrite && !prot.priv);
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      rd_q    <= in_range ? mem_rdata : '0;
    end else if (state == APB_CMP_ACCESS && psel && penable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Saturating count of error completions
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                                           err_count <= '0;
    else if (pready && pslverr && err_count != APB_CMP_ERR_CNT_MAX) err_count <= err_count + 8'd1;
  end

  apb_cmp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (pclk),
    .rst_n (preset_n),
    .we    (mem_we),
    .waddr (idx_q),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .raddr (idx_full[AW-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_mem_completer.sv
// Randomized scoreboard bench: the driver pushes expected responses from a
// behavioural memory model, a negedge monitor pops and compares on pready.
module tb_apb_mem_completer;

  localparam int DW = 32, AWD = 16, DEPTH = 256;

  logic           pclk = 1'b0;
  logic           preset_n;
  logic [AWD-1:0] paddr;
  logic [2:0]     pprot;
  logic           psel, penable, pwrite;
  logic [DW-1:0]  pwdata;
  logic [3:0]     pstrb;
  logic [3:0]     cfg_wait;
  logic           pready, pslverr;
  logic [DW-1:0]  prdata;
  logic [7:0]     err_count;

  always #5 pclk = ~pclk;

  apb_mem_completer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MEM_DEPTH(DEPTH), .PRIV_WRITE_ONLY(1)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .cfg_wait(cfg_wait), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .err_count(err_count)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // cycles from setup to pready inclusive; -1 = not checked
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [DEPTH];
  int          ref_errs;
  int          checks = 0, errors = 0;
  int          mon_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_errs = 0;
  endtask

  function automatic void ref_err();
    if (ref_errs < 255) ref_errs++;
  endfunction

  // Behavioural effect of one properly framed transfer
  task automatic ref_issue(input logic [15:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] pr, input int wt);
    int   idx;
    exp_t e;
    idx     = int'(a) / 4;
    e.err   = (idx >= DEPTH) || (w && !pr[0]);
    e.rdata = (!w && !e.err) ? ref_mem[idx] : 32'h0;
    e.lat   = 2 + wt;
    if (w && !e.err)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    if (e.err) ref_err();
    q.push_back(e);
  endtask

  task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] pr, input logic [3:0] wt);
    int n;
    ref_issue(a, w, d, s, pr, int'(wt));
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    pstrb = s; pprot = pr; cfg_wait = wt;
    @(posedge pclk); #1;
    penable  = 1'b1;
    cfg_wait = 4'($urandom);   // must not affect the transfer in flight
    n = 0;
    forever begin
      @(negedge pclk);
      if (pready) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL xfer_timeout: addr %h no pready after %0d cycles", a, n);
        void'(q.pop_back());
        break;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("err_count", 32'(err_count), 32'(ref_errs));
  endtask

  // Access phase with no setup cycle: same-cycle error completion
  task automatic no_setup(input logic [15:0] a, input logic w);
    exp_t e;
    e.rdata = 32'h0; e.err = 1'b1; e.lat = -1;
    q.push_back(e);
    ref_err();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; paddr = a; pwrite = w; pwdata = $urandom;
    pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("err_count_nosetup", 32'(err_count), 32'(ref_errs));
  endtask

  // Monitor: compare every completion against the scoreboard; idle outputs stay zero
  always @(negedge pclk) begin
    exp_t e;
    if (preset_n) begin
      if (psel && !penable) mon_lat = 1;
      else if (psel && penable) mon_lat++;
      checks++;
      if (pready) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready: prdata %h pslverr %b", prdata, pslverr);
        end else begin
          e = q.pop_front();
          if (prdata !== e.rdata || pslverr !== e.err || (e.lat >= 0 && mon_lat != e.lat)) begin
            errors++;
            $display("FAIL response: prdata %h pslverr %b lat %0d expected %h %b %0d",
                     prdata, pslverr, mon_lat, e.rdata, e.err, e.lat);
          end
        end
      end else if (prdata !== '0 || pslverr !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: prdata %h pslverr %b expected 0 0", prdata, pslverr);
      end
    end
  end

  initial begin
    logic [15:0] a;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pprot = '0; pwdata = '0; pstrb = '0; cfg_wait = '0;
    ref_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", 32'(pready), 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", 32'(pslverr), 0);
    chk("rst_err_count", 32'(err_count), 0);
    preset_n = 1'b1;

    // Basic write/read, wait states, partial strobes, null strobe
    xfer(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0);
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd3);
    xfer(16'h0012, 1'b1, 32'h11223344, 4'b0101, 3'b001, 4'd1);
    xfer(16'h0010, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
    xfer(16'h0010, 1'b1, 32'hCAFEF00D, 4'h0, 3'b001, 4'd0);
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd2);

    // Out of range write/read, and unprivileged write rejected then accepted
    xfer(16'h0400, 1'b1, 32'h55AA55AA, 4'hF, 3'b001, 4'd0);
    xfer(16'h0400, 1'b0, 32'h0, 4'h0, 3'b001, 4'd0);
    xfer(16'h0000, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
    xfer(16'h0020, 1'b1, 32'h0BADC0DE, 4'hF, 3'b000, 4'd0);
    xfer(16'h0020, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
    xfer(16'h0020, 1'b1, 32'h0BADC0DE, 4'hF, 3'b001, 4'd0);
    xfer(16'h0020, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);

    // Protocol violation: no setup cycle, write must not land
    no_setup(16'h0030, 1'b1);
    xfer(16'h0030, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);

    // Abort: psel drops mid-wait, no write, FSM back to idle
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0040; pwrite = 1'b1;
    pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001; cfg_wait = 4'd5;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    xfer(16'h0040, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
    chk("err_count_abort", 32'(err_count), 32'(ref_errs));

    // Reset while pready is high on a write: outputs drop, nothing written
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0044; pwrite = 1'b1;
    pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b001; cfg_wait = 4'd0;
    @(posedge pclk); #1; penable = 1'b1;
    #2;
    preset_n = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready), 0);
    chk("midrst_prdata", prdata, 0);
    chk("midrst_pslverr", 32'(pslverr), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    ref_reset();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    preset_n = 1'b1;
    xfer(16'h0044, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);

    // Random mix of in-range, out-of-range, privileged and unprivileged traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'h0400 + 16'($urandom_range(0, 16'hFBFF));
      else                           a = 16'($urandom_range(0, 16'h03FF));
      if ($urandom_range(0, 19) == 0) no_setup(a, 1'($urandom));
      else xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                4'($urandom_range(0, 4)));
    end

    // Saturation of the error counter
    for (int i = 0; i < 260; i++)
      xfer(16'h0400 + 16'($urandom_range(0, 255)), 1'b0, 32'h0, 4'h0, 3'b001, 4'd0);
    chk("err_count_sat", 32'(err_count), 32'd255);

    repeat (3) @(posedge pclk);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
